rsa_cmd_sequencer: RTL and testbench

Front-end control block of the RSA accelerator, between the ARM-facing command/data ports and the Montgomery multiplier / exponentiation core. Decodes 32-bit ARM commands, receives 1024-bit operand beats into operand registers, launches the core, returns the 512-bit result, and signals completion with a done/done-read handshake. It is the stage directly driven by the ARM side of the wrapper.

---
 rtl/rsa_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_rsa_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_cmd_sequencer.sv
// RSA accelerator command front end: decodes ARM commands, loads operands, launches the core, returns results.
// Optional COMPUTE watchdog enabled by defining CMD_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module rsa_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   arm_to_fpga_cmd,
    input  logic          arm_to_fpga_cmd_valid,
    output logic          fpga_to_arm_done,
    input  logic          fpga_to_arm_done_read,
    input  logic          arm_to_fpga_data_valid,
    output logic          arm_to_fpga_data_ready,
    input  logic [1023:0] arm_to_fpga_data,
    output logic          fpga_to_arm_data_valid,
    input  logic          fpga_to_arm_data_ready,
    output logic [1023:0] fpga_to_arm_data,
    output logic [511:0]  mod_q,
    output logic [1023:0] op_ab,
    output logic [1023:0] op_re,
    output logic          start_mont,
    output logic          start_exp,
    input  logic          core_done,
    input  logic [511:0]  core_result,
    output logic          cmd_error,
    output logic [3:0]    leds
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_TX      = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CMD_EXP   = 3'd0,
        CMD_MONT  = 3'd1,
        CMD_RMOD  = 3'd2,
        CMD_RRSQ  = 3'd3,
        CMD_REXP  = 3'd4,
        CMD_WRITE = 3'd5
    } cmd_e;

    state_e         state_q, state_d;
    cmd_e           cmd_q, cmd_d;
    logic           err_q, err_d;
    logic [511:0]   modulus_q, modulus_d;
    logic [1023:0]  op_ab_q, op_ab_d;
    logic [1023:0]  op_re_q, op_re_d;
    logic [511:0]   result_q, result_d;

`ifdef CMD_TIMEOUT_EN
    logic [31:0]    cnt_q, cnt_d;
`endif

    if (TIMEOUT_CYCLES == 0) begin : g_zero_timeout_unsupported
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_EXP;
            err_q     <= 1'b0;
            modulus_q <= '0;
            op_ab_q   <= '0;
            op_re_q   <= '0;
            result_q  <= '0;
`ifdef CMD_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            modulus_q <= modulus_d;
            op_ab_q   <= op_ab_d;
            op_re_q   <= op_re_d;
            result_q  <= result_d;
`ifdef CMD_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        err_d     = err_q;
        modulus_d = modulus_q;
        op_ab_d   = op_ab_q;
        op_re_d   = op_re_q;
        result_d  = result_q;
`ifdef CMD_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    err_d = 1'b0;
                    cmd_d = cmd_e'(arm_to_fpga_cmd[2:0]);
                    if (arm_to_fpga_cmd > 32'd5) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        case (cmd_e'(arm_to_fpga_cmd[2:0]))
                            CMD_EXP, CMD_MONT:            state_d = S_START;
                            CMD_RMOD, CMD_RRSQ, CMD_REXP: state_d = S_RX;
                            default:                      state_d = S_TX;
                        endcase
                    end
                end
            end
            S_RX: begin
                if (arm_to_fpga_data_valid) begin
                    case (cmd_q)
                        CMD_RMOD: modulus_d = arm_to_fpga_data[511:0];
                        CMD_RRSQ: op_ab_d   = arm_to_fpga_data;
                        default:  op_re_d   = arm_to_fpga_data;
                    endcase
                    state_d = S_DONE;
                end
            end
            S_START: begin
                state_d = S_COMPUTE;
`ifdef CMD_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_COMPUTE: begin
                // core_done wins over a watchdog expiry in the same cycle
                if (core_done) begin
                    result_d = core_result;
                    state_d  = S_DONE;
                end
`ifdef CMD_TIMEOUT_EN
                else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            S_TX: begin
                if (fpga_to_arm_data_ready) state_d = S_DONE;
            end
            S_DONE: begin
                if (fpga_to_arm_done_read) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arm_to_fpga_data_ready = (state_q == S_RX);
        fpga_to_arm_data_valid = (state_q == S_TX);
        fpga_to_arm_done       = (state_q == S_DONE);
        start_mont             = (state_q == S_START) && (cmd_q == CMD_MONT);
        start_exp              = (state_q == S_START) && (cmd_q == CMD_EXP);
        fpga_to_arm_data       = {512'b0, result_q};
        mod_q                  = modulus_q;
        op_ab                  = op_ab_q;
        op_re                  = op_re_q;
        cmd_error              = err_q;
        leds                   = {err_q, state_q};
    end

endmodule

// File: tb/tb_rsa_cmd_sequencer.sv
// Directed bench for rsa_cmd_sequencer; result beats are checked against a scoreboard queue.
// Exercises the watchdog path when CMD_TIMEOUT_EN is defined.
module tb_rsa_cmd_sequencer;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_CYC  = 16;
    localparam int          CORE_LAT = 10;
`else
    localparam int unsigned TO_CYC  = 16;
    localparam int          CORE_LAT = 100;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   arm_to_fpga_cmd;
    logic          arm_to_fpga_cmd_valid;
    logic          fpga_to_arm_done;
    logic          fpga_to_arm_done_read;
    logic          arm_to_fpga_data_valid;
    logic          arm_to_fpga_data_ready;
    logic [1023:0] arm_to_fpga_data;
    logic          fpga_to_arm_data_valid;
    logic          fpga_to_arm_data_ready;
    logic [1023:0] fpga_to_arm_data;
    logic [511:0]  mod_q;
    logic [1023:0] op_ab;
    logic [1023:0] op_re;
    logic          start_mont;
    logic          start_exp;
    logic          core_done;
    logic [511:0]  core_result;
    logic          cmd_error;
    logic [3:0]    leds;

    rsa_cmd_sequencer #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .mod_q                  (mod_q),
        .op_ab                  (op_ab),
        .op_re                  (op_re),
        .start_mont             (start_mont),
        .start_exp              (start_exp),
        .core_done              (core_done),
        .core_result            (core_result),
        .cmd_error              (cmd_error),
        .leds                   (leds)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [1023:0] sb_q[$];

    localparam logic [511:0]  MODV = {32'ha1223d5e, {14{32'h0f1e2d3c}}, 32'h8b7a9c4d};
    localparam logic [511:0]  RESV = {32'h5764fd11, {14{32'h13579bdf}}, 32'h2468cdec};
    localparam logic [1023:0] EXPV = {{16{32'h0badc0de}}, 480'h0, 32'h00010001};
    localparam logic [1023:0] RSQV = {{16{32'h3c3c5a5a}}, {16{32'h7e81a55a}}};

    task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int w;
        checks++;
        assert (obs === exp) else begin
            errors++;
            w = 0;
            for (int i = 15; i >= 0; i--) begin
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    w = i;
                    break;
                end
            end
            $error("FAIL %s word%0d got=%h exp=%h", tag, w, obs[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    // Result beats are compared against the scoreboard at the handshake cycle
    always @(negedge clk) begin
        if (!reset && fpga_to_arm_data_valid && fpga_to_arm_data_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL tx_unexpected got=%h exp=none", fpga_to_arm_data[63:0]);
            end else begin
                check("tx_beat", fpga_to_arm_data, sb_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        arm_to_fpga_cmd       = c;
        arm_to_fpga_cmd_valid = 1'b1;
        step();
        arm_to_fpga_cmd_valid = 1'b0;
    endtask

    task automatic ack_done(input string tag);
        check({tag, "_done_hi"}, fpga_to_arm_done, 1'b1);
        fpga_to_arm_done_read = 1'b1;
        step();
        fpga_to_arm_done_read = 1'b0;
        check({tag, "_done_lo"}, fpga_to_arm_done, 1'b0);
        check({tag, "_idle"}, leds[2:0], 3'd0);
    endtask

    task automatic load_operand(input string tag, input logic [31:0] c, input logic [1023:0] d);
        send_cmd(c);
        check({tag, "_ready"}, arm_to_fpga_data_ready, 1'b1);
        check({tag, "_leds_rx"}, leds, 4'h1);
        arm_to_fpga_data       = d;
        arm_to_fpga_data_valid = 1'b1;
        step();
        arm_to_fpga_data_valid = 1'b0;
        check({tag, "_ready_lo"}, arm_to_fpga_data_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog got=running exp=finished");
        $fatal(1, "Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    end

    initial begin
        int n;
        reset                  = 1'b1;
        arm_to_fpga_cmd        = '0;
        arm_to_fpga_cmd_valid  = 1'b0;
        fpga_to_arm_done_read  = 1'b0;
        arm_to_fpga_data_valid = 1'b0;
        arm_to_fpga_data       = '0;
        fpga_to_arm_data_ready = 1'b0;
        core_done              = 1'b0;
        core_result            = '0;
        #12;
        check("rst_ctrl", {fpga_to_arm_done, arm_to_fpga_data_ready, fpga_to_arm_data_valid,
                           start_mont, start_exp, cmd_error, leds}, '0);
        check("rst_mod", mod_q, '0);
        check("rst_opab", op_ab, '0);
        check("rst_opre", op_re, '0);
        check("rst_txdata", fpga_to_arm_data, '0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // WRITE right after reset returns a zero result; ARM holds off ready for a while
        sb_q.push_back('0);
        send_cmd(32'd5);
        check("w0_valid", fpga_to_arm_data_valid, 1'b1);
        step();
        step();
        check("w0_hold", {fpga_to_arm_data_valid, leds}, {1'b1, 4'h4});
        fpga_to_arm_data_ready = 1'b1;
        step();
        fpga_to_arm_data_ready = 1'b0;
        check("w0_valid_lo", fpga_to_arm_data_valid, 1'b0);
        ack_done("w0");

        load_operand("rsq", 32'd3, {512'h2, 512'h1});
        check("rsq_opab", op_ab, {512'h2, 512'h1});
        step();
        check("rsq_done_held", fpga_to_arm_done, 1'b1);
        ack_done("rsq");

        load_operand("mod", 32'd2, {{16{32'hffff0000}}, MODV});
        check("mod_modq", mod_q, MODV);
        check("mod_opab_kept", op_ab, {512'h2, 512'h1});
        arm_to_fpga_cmd       = 32'd1;
        arm_to_fpga_cmd_valid = 1'b1;
        step();
        arm_to_fpga_cmd_valid = 1'b0;
        check("done_ignores_cmd", {leds, start_mont}, {4'h5, 1'b0});
        ack_done("mod");

        send_cmd(32'd1);
        check("mont_start", {start_mont, start_exp, leds}, {1'b1, 1'b0, 4'h2});
        step();
        check("mont_start_lo", {start_mont, leds}, {1'b0, 4'h3});
        n = 0;
        for (int i = 0; i < CORE_LAT - 1; i++) begin
            step();
            if (start_mont || start_exp || fpga_to_arm_done) n++;
        end
        check("mont_wait_quiet", n, 0);
        core_done   = 1'b1;
        core_result = RESV;
        step();
        core_done   = 1'b0;
        core_result = '1;
        check("mont_done", {fpga_to_arm_done, leds}, {1'b1, 4'h5});
        ack_done("mont");

        // core_done while idle must not touch the result
        core_done   = 1'b1;
        core_result = {16{32'hdeadbeef}};
        step();
        core_done   = 1'b0;

        sb_q.push_back({512'b0, RESV});
        fpga_to_arm_data_ready = 1'b1;
        send_cmd(32'd5);
        check("w1_valid", fpga_to_arm_data_valid, 1'b1);
        step();
        fpga_to_arm_data_ready = 1'b0;
        ack_done("w1");

        send_cmd(32'h7);
        check("bad_state", {arm_to_fpga_data_ready, fpga_to_arm_done, cmd_error, leds},
              {1'b0, 1'b1, 1'b1, 4'hd});
        ack_done("bad");
        check("bad_sticky", leds, 4'h8);
        load_operand("exp", 32'd4, EXPV);
        check("exp_err_clr", cmd_error, 1'b0);
        check("exp_opre", op_re, EXPV);
        ack_done("exp");

`ifdef CMD_TIMEOUT_EN
        send_cmd(32'd0);
        check("to_start", {start_exp, start_mont}, 2'b10);
        step();
        n = 0;
        while (!fpga_to_arm_done && n < 4 * TO_CYC) begin
            step();
            n++;
        end
        check("to_cycles", n, TO_CYC);
        check("to_err", cmd_error, 1'b1);
        ack_done("to");
        sb_q.push_back({512'b0, RESV});
        fpga_to_arm_data_ready = 1'b1;
        send_cmd(32'd5);
        step();
        fpga_to_arm_data_ready = 1'b0;
        ack_done("to_w");
`endif

        send_cmd(32'd3);
        check("rst_rx_ready", arm_to_fpga_data_ready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_rx_ctrl", {arm_to_fpga_data_ready, fpga_to_arm_done, cmd_error, leds}, '0);
        check("rst_rx_opab", op_ab, '0);
        check("rst_rx_mod", mod_q, '0);
        @(negedge clk);
        reset = 1'b0;
        step();
        load_operand("post", 32'd4, RSQV);
        check("post_opre", op_re, RSQV);
        check("post_opab", op_ab, '0);
        ack_done("post");

        step();
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
